// File: rtl/addsub_32.sv
// 32-bit two's-complement adder/subtractor: two-level carry-lookahead core
// (4-bit groups) feeding a single output register stage with ALU status flags.
module addsub_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);

    localparam int unsigned NGRP = WIDTH / 4;

    logic [WIDTH-1:0] b_c;
    logic [WIDTH-1:0] g_c;
    logic [WIDTH-1:0] p_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH:0]   carry_c;
    logic [NGRP-1:0]  grp_g_c;
    logic [NGRP-1:0]  grp_p_c;
    logic [NGRP:0]    grp_c_c;
    logic             ovf_c;

    // Subtraction is X + ~Y + 1; the inverted operand and carry-in both come from Sub.
    assign b_c = Y ^ {WIDTH{Sub}};
    assign g_c = X & b_c;
    assign p_c = X ^ b_c;

    // Group generate/propagate over each 4-bit slice.
    always_comb begin
        grp_g_c = '0;
        grp_p_c = '0;
        for (int k = 0; k < int'(NGRP); k++) begin
            grp_g_c[k] = g_c[4*k+3]
                       | (p_c[4*k+3] & g_c[4*k+2])
                       | (p_c[4*k+3] & p_c[4*k+2] & g_c[4*k+1])
                       | (p_c[4*k+3] & p_c[4*k+2] & p_c[4*k+1] & g_c[4*k]);
            grp_p_c[k] = &p_c[4*k +: 4];
        end
    end

    // Second-level lookahead: each group carry is a flat sum of products of
    // lower group terms and the carry-in, so no carry ripples group to group.
    always_comb begin
        logic acc;
        logic pp;
        acc     = 1'b0;
        pp      = 1'b0;
        grp_c_c = '0;
        grp_c_c[0] = Sub;
        for (int k = 1; k <= int'(NGRP); k++) begin
            acc = grp_g_c[k-1];
            pp  = grp_p_c[k-1];
            for (int j = k - 2; j >= 0; j--) begin
                acc = acc | (pp & grp_g_c[j]);
                pp  = pp & grp_p_c[j];
            end
            grp_c_c[k] = acc | (pp & Sub);
        end
    end

    // Bit carries inside each group, expanded from that group's carry-in.
    always_comb begin
        carry_c = '0;
        for (int k = 0; k < int'(NGRP); k++) begin
            carry_c[4*k]   = grp_c_c[k];
            carry_c[4*k+1] = g_c[4*k] | (p_c[4*k] & grp_c_c[k]);
            carry_c[4*k+2] = g_c[4*k+1]
                           | (p_c[4*k+1] & g_c[4*k])
                           | (p_c[4*k+1] & p_c[4*k] & grp_c_c[k]);
            carry_c[4*k+3] = g_c[4*k+2]
                           | (p_c[4*k+2] & g_c[4*k+1])
                           | (p_c[4*k+2] & p_c[4*k+1] & g_c[4*k])
                           | (p_c[4*k+2] & p_c[4*k+1] & p_c[4*k] & grp_c_c[k]);
        end
        carry_c[WIDTH] = grp_c_c[NGRP];
    end

    assign sum_c = p_c ^ carry_c[WIDTH-1:0];
    assign ovf_c = carry_c[WIDTH] ^ carry_c[WIDTH-1];

    // Output stage: flags load together with S; idle cycles hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b1;
            Negative  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S        <= sum_c;
                Cout     <= carry_c[WIDTH];
                Overflow <= ovf_c;
                Zero     <= (sum_c == '0);
                Negative <= sum_c[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_addsub_32.sv
// Bench for addsub_32: directed flag vectors, hold, reset and random traffic
// checked through an expected-result queue at one-cycle latency.
module tb_addsub_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] X;
    logic [31:0] Y;
    logic        Sub;
    logic        out_valid;
    logic [31:0] S;
    logic        Cout;
    logic        Overflow;
    logic        Zero;
    logic        Negative;

    // {out_valid, S, Cout, Overflow, Zero, Negative}
    logic [36:0] obs;
    logic [36:0] exp_q[$];
    logic [36:0] exp;
    int          passed = 0;
    int          total  = 0;

    localparam logic [36:0] RST_VAL = {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    assign obs = {out_valid, S, Cout, Overflow, Zero, Negative};

    addsub_32 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .X        (X),
        .Y        (Y),
        .Sub      (Sub),
        .out_valid(out_valid),
        .S        (S),
        .Cout     (Cout),
        .Overflow (Overflow),
        .Zero     (Zero),
        .Negative (Negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

    // Behavioural 33-bit reference.
    function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        logic [31:0] b;
        logic [32:0] r;
        logic        v;
        b = sub ? ~y : y;
        r = {1'b0, x} + {1'b0, b} + {32'h0, sub};
        v = (x[31] == b[31]) && (r[31] != x[31]);
        return {1'b1, r[31:0], r[32], v, (r[31:0] == 32'h0), r[31]};
    endfunction

    task automatic test_reset();
        in_valid = 1'b0; X = '0; Y = '0; Sub = 1'b0; rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== RST_VAL) $display("FAIL reset_async got=%h exp=%h", obs, RST_VAL);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs !== RST_VAL) $display("FAIL reset_hold got=%h exp=%h", obs, RST_VAL);
        else passed++;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (obs !== RST_VAL) $display("FAIL reset_idle[%0d] got=%h exp=%h", i, obs, RST_VAL);
            else passed++;
        end
    endtask

    task automatic test_directed();
        vec_t v[10];
        v[0] = '{32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0};
        v[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        v[2] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
        v[3] = '{32'h00000020, 32'h00000010, 1'b1, 32'h00000010, 1'b1, 1'b0, 1'b0, 1'b0};
        v[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
        v[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        v[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        v[7] = '{32'h00000010, 32'h00000020, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0, 1'b1};
        v[8] = '{32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 1'b0, 1'b0, 1'b0, 1'b0};
        v[9] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            X = v[i].x; Y = v[i].y; Sub = v[i].sub; in_valid = 1'b1;
            exp_q.push_back({1'b1, v[i].s, v[i].c, v[i].v, v[i].z, v[i].n});
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            total++;
            if (obs !== exp) $display("FAIL directed[%0d] got=%h exp=%h", i, obs, exp);
            else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_hold();
        logic [36:0] held;
        X = 32'h00001234; Y = 32'h00000001; Sub = 1'b0; in_valid = 1'b1;
        exp_q.push_back({1'b1, 32'h00001235, 4'b0000});
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) $display("FAIL hold_load got=%h exp=%h", obs, exp);
        else passed++;
        held = {1'b0, 32'h00001235, 4'b0000};
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            X = $urandom; Y = $urandom; Sub = 1'($urandom);
            @(posedge clk); #1;
            total++;
            if (obs !== held) $display("FAIL hold[%0d] got=%h exp=%h", i, obs, held);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        X = 32'h5; Y = 32'h6; Sub = 1'b0; in_valid = 1'b1;
        exp_q.push_back({1'b1, 32'h0000000B, 4'b0000});
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) $display("FAIL rstmid_load got=%h exp=%h", obs, exp);
        else passed++;
        X = 32'h7; Y = 32'h8;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== RST_VAL) $display("FAIL rstmid_async got=%h exp=%h", obs, RST_VAL);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (obs !== RST_VAL) $display("FAIL rstmid_discard got=%h exp=%h", obs, RST_VAL);
        else passed++;
    endtask

    task automatic test_random(input int n);
        int errs;
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom);
            case ($urandom_range(0, 3))
                0: begin x = (32'h1 << (4 * $urandom_range(1, 7))) - 32'h1; y = s ? 32'hFFFFFFFF : 32'h1; end
                1: y = ~x;
                default: ;
            endcase
            X = x; Y = y; Sub = s; in_valid = 1'b1;
            exp_q.push_back(model(x, y, s));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            total++;
            if (obs !== exp) begin
                if (errs < 10) $display("FAIL random[%0d] x=%h y=%h sub=%b got=%h exp=%h", i, x, y, s, obs, exp);
                errs++;
            end else passed++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random(10000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
